// File: rtl/ti_sbox4_pipe.sv
// ti_sbox4_pipe
//   Three-share threshold-implementation layer for LANES parallel 4-bit S-boxes
//   decomposed as S = G o F (F and G quadratic). Each lane computes the shared F,
//   registers it (glitch barrier, optionally remasked with fresh randomness),
//   computes the shared G and registers the output shares.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_s1..in_s3        input shares, lane k at bits [4k+3:4k]
//   rnd                 fresh randomness, lane k: r1=[8k+3:8k], r2=[8k+7:8k+4]
//   out_valid/out_ready output handshake
//   out_s1..out_s3      output shares, lane k at bits [4k+3:4k]
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. valid holds its item until it is taken; ready may depend
// combinationally on out_ready (a full pipe accepts when the output drains in
// the same cycle).
module ti_sbox4_pipe #(
  parameter int          LANES   = 4,
  parameter logic [63:0] F_TABLE = 64'hFEDCBA9876543210,
  parameter logic [63:0] G_TABLE = 64'hFEDCBA9876543210,
  parameter bit          REFRESH = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*LANES-1:0]   in_s1,
  input  logic [4*LANES-1:0]   in_s2,
  input  logic [4*LANES-1:0]   in_s3,
  input  logic [8*LANES-1:0]   rnd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*LANES-1:0]   out_s1,
  output logic [4*LANES-1:0]   out_s2,
  output logic [4*LANES-1:0]   out_s3
);

  localparam int W = 4 * LANES;

  // ANF of the four output coordinates: bit [16c+m] is the coefficient of
  // monomial m (bit i of m set = variable x_i present) in coordinate c.
  function automatic logic [63:0] anf_of(input logic [63:0] tbl);
    logic [15:0] t;
    logic [63:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int x = 0; x < 16; x++) t[4'(x)] = tbl[6'(4 * x + c)];
      // Moebius transform over GF(2)
      for (int i = 0; i < 4; i++)
        for (int m = 0; m < 16; m++)
          if (((m >> i) & 1) != 0) t[4'(m)] = t[4'(m)] ^ t[4'(m ^ (1 << i))];
      for (int m = 0; m < 16; m++) res[6'(16 * c + m)] = t[4'(m)];
    end
    return res;
  endfunction

  function automatic int max_deg(input logic [63:0] anf);
    int d;
    int w;
    d = 0;
    for (int c = 0; c < 4; c++)
      for (int m = 0; m < 16; m++)
        if (anf[6'(16 * c + m)]) begin
          w = 0;
          for (int i = 0; i < 4; i++) w = w + ((m >> i) & 1);
          if (w > d) d = w;
        end
    return d;
  endfunction

  // One output share of a quadratic function. p is the share owning the linear
  // terms, q the other share feeding the cross terms; the omitted share never
  // reaches this function, so non-completeness is structural.
  function automatic logic [3:0] share_eval(input logic [63:0] anf,
                                            input logic [3:0]  p,
                                            input logic [3:0]  q,
                                            input bit          with_const);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) begin
      r[2'(c)] = with_const & anf[6'(16 * c)];
      for (int i = 0; i < 4; i++)
        if (anf[6'(16 * c + (1 << i))]) r[2'(c)] = r[2'(c)] ^ p[2'(i)];
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++)
          if (anf[6'(16 * c + (1 << i) + (1 << j))])
            r[2'(c)] = r[2'(c)] ^ (p[2'(i)] & p[2'(j)]) ^ (p[2'(i)] & q[2'(j)])
                                ^ (q[2'(i)] & p[2'(j)]);
    end
    return r;
  endfunction

  localparam logic [63:0] F_ANF = anf_of(F_TABLE);
  localparam logic [63:0] G_ANF = anf_of(G_TABLE);

  if (max_deg(F_ANF) > 2) begin : g_f_cubic
    $error("ti_sbox4_pipe: F_TABLE has an ANF monomial of degree > 2");
  end
  if (max_deg(G_ANF) > 2) begin : g_g_cubic
    $error("ti_sbox4_pipe: G_TABLE has an ANF monomial of degree > 2");
  end
  if (LANES < 1 || LANES > 32) begin : g_lanes_range
    $error("ti_sbox4_pipe: LANES must be in 1..32");
  end

  logic         v1, v2, adv2;
  logic [W-1:0] a1, a2, a3;
  logic [W-1:0] n1, n2, n3;
  logic [W-1:0] g1, g2, g3;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [3:0] r1, r2;
    // rnd is masked off (not left unconnected) when refresh is disabled
    assign r1 = rnd[8*k +: 4]     & {4{REFRESH}};
    assign r2 = rnd[8*k + 4 +: 4] & {4{REFRESH}};

    assign n1[4*k +: 4] = share_eval(F_ANF, in_s2[4*k +: 4], in_s3[4*k +: 4], 1'b1) ^ r1;
    assign n2[4*k +: 4] = share_eval(F_ANF, in_s3[4*k +: 4], in_s1[4*k +: 4], 1'b0) ^ r2;
    assign n3[4*k +: 4] = share_eval(F_ANF, in_s1[4*k +: 4], in_s2[4*k +: 4], 1'b0) ^ r1 ^ r2;

    assign g1[4*k +: 4] = share_eval(G_ANF, a2[4*k +: 4], a3[4*k +: 4], 1'b1);
    assign g2[4*k +: 4] = share_eval(G_ANF, a3[4*k +: 4], a1[4*k +: 4], 1'b0);
    assign g3[4*k +: 4] = share_eval(G_ANF, a1[4*k +: 4], a2[4*k +: 4], 1'b0);
  end

  assign adv2      = !v2 || out_ready;
  assign in_ready  = !v1 || adv2;
  assign out_valid = v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      a1     <= '0;
      a2     <= '0;
      a3     <= '0;
      out_s1 <= '0;
      out_s2 <= '0;
      out_s3 <= '0;
    end else begin
      if (adv2) v2 <= v1;
      if (in_ready) v1 <= in_valid;
      if (in_ready && in_valid) begin
        a1 <= n1;
        a2 <= n2;
        a3 <= n3;
      end
      if (adv2 && v1) begin
        out_s1 <= g1;
        out_s2 <= g2;
        out_s3 <= g3;
      end
    end
  end

endmodule

// File: tb/tb_ti_sbox4_pipe.sv
// Bench for ti_sbox4_pipe. Four instances share clk/rst:
//   u0 defaults (identity F/G, refresh on), u2 same with refresh off
//   (u0/u2 driven by group A signals, 4 lanes);
//   u1 quadratic F, identity G; u3 identity F, same quadratic G
//   (u1/u3 driven by group B signals, 1 lane). Both compute the same mapping.
module tb_ti_sbox4_pipe;

  localparam logic [63:0] QTAB = 64'hEEDCAA9866542210;

  logic clk, rst;

  // group A
  logic        a_in_valid, a_out_ready;
  logic [15:0] a_s1, a_s2, a_s3;
  logic [31:0] a_rnd;
  logic        u0_in_ready, u0_out_valid, u2_in_ready, u2_out_valid;
  logic [15:0] u0_o1, u0_o2, u0_o3, u2_o1, u2_o2, u2_o3;

  // group B
  logic        b_in_valid, b_out_ready;
  logic [3:0]  b_s1, b_s2, b_s3;
  logic [7:0]  b_rnd;
  logic        u1_in_ready, u1_out_valid, u3_in_ready, u3_out_valid;
  logic [3:0]  u1_o1, u1_o2, u1_o3, u3_o1, u3_o2, u3_o3;

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0] exp_q[$];
  logic [3:0] xs[16];

  typedef struct {
    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] s3;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  ti_sbox4_pipe u0 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(u0_in_ready),
    .in_s1(a_s1), .in_s2(a_s2), .in_s3(a_s3), .rnd(a_rnd),
    .out_valid(u0_out_valid), .out_ready(a_out_ready),
    .out_s1(u0_o1), .out_s2(u0_o2), .out_s3(u0_o3)
  );

  ti_sbox4_pipe #(.REFRESH(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(u2_in_ready),
    .in_s1(a_s1), .in_s2(a_s2), .in_s3(a_s3), .rnd(a_rnd),
    .out_valid(u2_out_valid), .out_ready(a_out_ready),
    .out_s1(u2_o1), .out_s2(u2_o2), .out_s3(u2_o3)
  );

  ti_sbox4_pipe #(.LANES(1), .F_TABLE(QTAB)) u1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(u1_in_ready),
    .in_s1(b_s1), .in_s2(b_s2), .in_s3(b_s3), .rnd(b_rnd),
    .out_valid(u1_out_valid), .out_ready(b_out_ready),
    .out_s1(u1_o1), .out_s2(u1_o2), .out_s3(u1_o3)
  );

  ti_sbox4_pipe #(.LANES(1), .G_TABLE(QTAB)) u3 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(u3_in_ready),
    .in_s1(b_s1), .in_s2(b_s2), .in_s3(b_s3), .rnd(b_rnd),
    .out_valid(u3_out_valid), .out_ready(b_out_ready),
    .out_s1(u3_o1), .out_s2(u3_o2), .out_s3(u3_o3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] q_model(input logic [3:0] x);
    logic [63:0] t;
    t = QTAB;
    return 4'(t >> {x, 2'b00});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive_b(input logic [3:0] x);
    b_s1       = 4'($urandom_range(0, 15));
    b_s2       = 4'($urandom_range(0, 15));
    b_s3       = x ^ b_s1 ^ b_s2;
    b_rnd      = 8'($urandom_range(0, 255));
    b_in_valid = 1'b1;
  endtask

  task automatic check_b_out(input string name, input logic [3:0] e);
    check({name, "_v1"}, 64'(u1_out_valid), 64'd1);
    check({name, "_v3"}, 64'(u3_out_valid), 64'd1);
    check({name, "_u1"}, 64'(u1_o1 ^ u1_o2 ^ u1_o3), 64'(e));
    check({name, "_u3"}, 64'(u3_o1 ^ u3_o2 ^ u3_o3), 64'(e));
  endtask

  // One isolated item through group A; returns the captured output shares.
  task automatic apply_a(input string name, input vec_t v, input logic [31:0] r,
                         output logic [47:0] sh0, output logic [47:0] sh2);
    @(negedge clk);
    check({name, "_rdy"}, 64'(u0_in_ready), 64'd1);
    a_s1 = v.s1; a_s2 = v.s2; a_s3 = v.s3; a_rnd = r;
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_rnd = 32'($urandom());
    check({name, "_lat1"}, 64'(u0_out_valid), 64'd0);
    @(negedge clk);
    check({name, "_lat2"}, 64'(u0_out_valid), 64'd1);
    check({name, "_u0"}, 64'(u0_o1 ^ u0_o2 ^ u0_o3), 64'(v.exp));
    check({name, "_u2"}, 64'(u2_o1 ^ u2_o2 ^ u2_o3), 64'(v.exp));
    sh0 = {u0_o1, u0_o2, u0_o3};
    sh2 = {u2_o1, u2_o2, u2_o3};
    @(negedge clk);
    check({name, "_once"}, 64'(u0_out_valid), 64'd0);
  endtask

  // Back-to-back stream of n items on group B with out_ready held high.
  task automatic stream_b(input string name, input int n);
    logic [3:0] e;
    b_out_ready = 1'b1;
    for (int cyc = 0; cyc < n + 3; cyc++) begin
      @(negedge clk);
      if (cyc < n) begin
        check({name, "_rdy"}, 64'(u1_in_ready & u3_in_ready), 64'd1);
        drive_b(xs[cyc]);
        exp_q.push_back(q_model(xs[cyc]));
      end else begin
        b_in_valid = 1'b0;
      end
      if (cyc >= 2 && cyc < n + 2) begin
        e = exp_q.pop_front();
        check_b_out(name, e);
      end
      if (cyc == n + 2) check({name, "_idle"}, 64'(u1_out_valid | u3_out_valid), 64'd0);
    end
  endtask

  initial begin
    logic [47:0] s0a, s2a, s0b, s2b;
    logic [11:0] snap;
    logic [3:0]  e;

    vecs[0] = '{16'h1234, 16'h0F0F, 16'hA5A5, 16'hB89E};
    vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{16'h1111, 16'h2222, 16'h4444, 16'h7777};
    vecs[5] = '{16'hDEAD, 16'hBEEF, 16'h0000, 16'h6042};
    vecs[6] = '{16'h8421, 16'h8421, 16'h0001, 16'h0001};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00};

    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_s1 = '0; a_s2 = '0; a_s3 = '0; a_rnd = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_s1 = '0; b_s2 = '0; b_s3 = '0; b_rnd = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(u0_out_valid | u1_out_valid), 64'd0);
    check("rst_ready", 64'(u0_in_ready & u1_in_ready), 64'd1);
    check("rst_shares", 64'({u0_o1, u0_o2, u0_o3}), 64'd0);
    rst = 1'b0;

    // table-driven vectors, random masks
    for (int i = 0; i < 8; i++) apply_a($sformatf("vec%0d", i), vecs[i], 32'($urandom()), s0a, s2a);

    // refresh: same shares, rnd all-zero versus all-one
    apply_a("ref0", vecs[0], 32'h0000_0000, s0a, s2a);
    apply_a("ref1", vecs[0], 32'hFFFF_FFFF, s0b, s2b);
    check("refresh_differs", 64'(s0a != s0b), 64'd1);
    check("norefresh_same", 64'(s2a), 64'(s2b));
    check("rnd0_matches_norefresh", 64'(s0a), 64'(s2a));

    // streaming on the quadratic instances
    xs[0] = 4'd3; xs[1] = 4'd7; xs[2] = 4'd0; xs[3] = 4'd15;
    check("qmodel_3", 64'(q_model(4'd3)), 64'd2);
    check("qmodel_15", 64'(q_model(4'd15)), 64'd14);
    stream_b("strm4", 4);
    for (int i = 0; i < 16; i++) xs[i] = 4'(i);
    stream_b("strm16", 16);

    // backpressure: three items, output stalled for five cycles
    b_out_ready = 1'b0;
    @(negedge clk);
    check("bp_rdy0", 64'(u1_in_ready), 64'd1);
    drive_b(4'h3); exp_q.push_back(q_model(4'h3));
    @(negedge clk);
    check("bp_rdy1", 64'(u1_in_ready), 64'd1);
    drive_b(4'h7); exp_q.push_back(q_model(4'h7));
    @(negedge clk);
    drive_b(4'hF);
    check("bp_full", 64'(u1_in_ready | u3_in_ready), 64'd0);
    check_b_out("bp_head", exp_q[0]);
    snap = {u1_o1, u1_o2, u1_o3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_rdy", 64'(u1_in_ready), 64'd0);
      check("bp_hold_valid", 64'(u1_out_valid), 64'd1);
      check("bp_stable", 64'({u1_o1, u1_o2, u1_o3}), 64'(snap));
    end
    @(negedge clk);
    b_out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 64'(u1_in_ready), 64'd1);
    exp_q.push_back(q_model(4'hF));
    e = exp_q.pop_front();
    check_b_out("bp_out0", e);
    @(negedge clk);
    b_in_valid = 1'b0;
    e = exp_q.pop_front();
    check_b_out("bp_out1", e);
    @(negedge clk);
    e = exp_q.pop_front();
    check_b_out("bp_out2", e);
    @(negedge clk);
    check("bp_drained", 64'(u1_out_valid), 64'd0);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset while both stages are full and stalled
    b_out_ready = 1'b0;
    @(negedge clk); drive_b(4'h5);
    @(negedge clk); drive_b(4'h9);
    @(negedge clk);
    b_in_valid = 1'b0;
    check("rs_full", 64'(u1_in_ready), 64'd0);
    check("rs_valid", 64'(u1_out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rs_async_valid", 64'(u1_out_valid | u3_out_valid), 64'd0);
    check("rs_async_shares", 64'({u1_o1, u1_o2, u1_o3, u3_o1, u3_o2, u3_o3}), 64'd0);
    check("rs_async_ready", 64'(u1_in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    b_out_ready = 1'b1;
    @(negedge clk);
    drive_b(4'hB);
    @(negedge clk);
    b_in_valid = 1'b0;
    check("rs_lat1", 64'(u1_out_valid), 64'd0);
    @(negedge clk);
    check_b_out("rs_first", 4'hA);
    @(negedge clk);
    check("rs_once", 64'(u1_out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
